multi_cycle_controller: RTL

Control FSM that sequences the ARM datapath over several cycles per instruction. It supplies every mux select, write enable and ALU control the datapath needs. It also owns the NZCV flag register and ARM condition evaluation. It sits beside the datapath and shares a unified instruction/data memory port with it.

---
 rtl/arm_pkg.sv | 55 +++++
 rtl/multi_cycle_controller_if.sv | 30 +++
 rtl/cond_logic.sv | 50 +++++
 rtl/multi_cycle_controller.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared encodings for the multi-cycle ARM controller: FSM states, datapath
// select codes, ALU controls and condition codes.
package arm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'ha;
    localparam logic [3:0] COND_LT = 4'hb;
    localparam logic [3:0] COND_GT = 4'hc;
    localparam logic [3:0] COND_LE = 4'hd;
    localparam logic [3:0] COND_AL = 4'he;

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
// instr/alu_flags flow into the controller; every select and strobe flows out.
interface multi_cycle_controller_if;
    logic [19:0] instr;
    logic [3:0]  alu_flags;
    logic        pc_write;
    logic        adr_src;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic [1:0]  imm_src;
    logic [1:0]  reg_src;
    logic [1:0]  alu_ctl;
    logic [3:0]  state;

    modport master (
        input  instr, alu_flags,
        output pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a,
               alu_src_b, result_src, imm_src, reg_src, alu_ctl, state
    );

    modport slave (
        output instr, alu_flags,
        input  pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a,
               alu_src_b, result_src, imm_src, reg_src, alu_ctl, state
    );
endinterface

// File: rtl/cond_logic.sv
// NZCV flag register and ARM condition evaluation. flag_write[1] loads N/Z,
// flag_write[0] loads C/V; cond_ex always reflects the registered flags.
module cond_logic
    import arm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_write,
    output logic       cond_ex
);

    logic [3:0] r_flags;
    logic       w_n, w_z, w_c, w_v;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (flag_write[1]) r_flags[3:2] <= alu_flags[3:2];
            if (flag_write[0]) r_flags[1:0] <= alu_flags[1:0];
        end
    end

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = w_z;
            COND_NE: cond_ex = ~w_z;
            COND_CS: cond_ex = w_c;
            COND_CC: cond_ex = ~w_c;
            COND_MI: cond_ex = w_n;
            COND_PL: cond_ex = ~w_n;
            COND_VS: cond_ex = w_v;
            COND_VC: cond_ex = ~w_v;
            COND_HI: cond_ex = w_c & ~w_z;
            COND_LS: cond_ex = ~w_c | w_z;
            COND_GE: cond_ex = (w_n == w_v);
            COND_LT: cond_ex = (w_n != w_v);
            COND_GT: cond_ex = ~w_z & (w_n == w_v);
            COND_LE: cond_ex = w_z | (w_n != w_v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle ARM control FSM: sequences fetch/decode/execute and drives all
// datapath selects and strobes; flags and condition checks live in cond_logic.
module multi_cycle_controller
    import arm_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    multi_cycle_controller_if.master bus
);

    state_t     r_state, w_next;
    logic       r_cond_hold;

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic       w_rd15;
    logic       w_cond_ex;
    logic       w_wb_cond;
    logic [1:0] w_flag_write;

    logic [1:0] w_dp_ctl;
    logic       w_dp_valid;
    logic       w_dp_arith;

    logic       w_pc_write, w_adr_src, w_mem_write, w_ir_write, w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b, w_result_src, w_imm_src, w_reg_src, w_alu_ctl;

    assign w_cond  = bus.instr[19:16];
    assign w_op    = bus.instr[15:14];
    assign w_funct = bus.instr[13:8];
    assign w_rd15  = (bus.instr[3:0] == 4'hf);

    cond_logic u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond       (w_cond),
        .alu_flags  (bus.alu_flags),
        .flag_write (w_flag_write),
        .cond_ex    (w_cond_ex)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_FETCH;
            r_cond_hold <= 1'b0;
        end else begin
            r_state <= w_next;
            // ALUWB must see the condition as it was before this instruction's own flag update
            if (r_state == S_EXECUTER || r_state == S_EXECUTEI)
                r_cond_hold <= w_cond_ex;
        end
    end

    assign w_wb_cond = (r_state == S_ALUWB) ? r_cond_hold : w_cond_ex;

    always_comb begin
        w_dp_ctl   = ALU_ADD;
        w_dp_valid = 1'b0;
        w_dp_arith = 1'b0;
        case (w_funct[4:1])
            4'b0100: begin w_dp_ctl = ALU_ADD; w_dp_valid = 1'b1; w_dp_arith = 1'b1; end
            4'b0010: begin w_dp_ctl = ALU_SUB; w_dp_valid = 1'b1; w_dp_arith = 1'b1; end
            4'b0000: begin w_dp_ctl = ALU_AND; w_dp_valid = 1'b1; end
            4'b1100: begin w_dp_ctl = ALU_ORR; w_dp_valid = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        w_pc_write   = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = SRCB_REG;
        w_result_src = RES_ALUOUT;
        w_imm_src    = IMM_DP;
        w_alu_ctl    = ALU_ADD;
        w_flag_write = 2'b00;
        // Register-port steering holds from DECODE through write-back (STR reads rd late)
        w_reg_src    = (r_state == S_FETCH) ? 2'b00 : {w_op == OP_MEM, w_op == OP_BR};
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALU;
                w_pc_write   = 1'b1;
                w_next       = S_DECODE;
            end
            S_DECODE: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALU;
                case (w_op)
                    OP_MEM: begin w_imm_src = IMM_MEM; w_next = S_MEMADR; end
                    OP_DP:  w_next = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:  begin w_imm_src = IMM_BR; w_next = S_BRANCH; end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_b = SRCB_IMM;
                w_imm_src   = IMM_MEM;
                w_alu_ctl   = w_funct[3] ? ALU_ADD : ALU_SUB;
                w_next      = w_funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adr_src    = 1'b1;
                w_result_src = RES_ALUOUT;
                w_next       = S_MEMWB;
            end
            S_MEMWRITE: begin
                w_adr_src    = 1'b1;
                w_result_src = RES_ALUOUT;
                w_mem_write  = w_cond_ex;
                w_next       = S_FETCH;
            end
            S_MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = w_wb_cond & ~w_rd15;
                w_pc_write   = w_wb_cond & w_rd15;
                w_next       = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI: begin
                w_alu_src_b  = (r_state == S_EXECUTEI) ? SRCB_IMM : SRCB_REG;
                w_imm_src    = IMM_DP;
                w_alu_ctl    = w_dp_ctl;
                if (w_funct[0] && w_cond_ex && w_dp_valid)
                    w_flag_write = {1'b1, w_dp_arith};
                w_next       = S_ALUWB;
            end
            S_ALUWB: begin
                w_result_src = RES_ALUOUT;
                w_reg_write  = w_wb_cond & ~w_rd15;
                w_pc_write   = w_wb_cond & w_rd15;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_b  = SRCB_IMM;
                w_imm_src    = IMM_BR;
                w_result_src = RES_ALU;
                w_pc_write   = w_cond_ex;
                w_next       = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Strobes are masked by reset directly so nothing fires while reset is held low
    assign bus.pc_write   = w_pc_write  & reset;
    assign bus.mem_write  = w_mem_write & reset;
    assign bus.ir_write   = w_ir_write  & reset;
    assign bus.reg_write  = w_reg_write & reset;
    assign bus.adr_src    = w_adr_src;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.result_src = w_result_src;
    assign bus.imm_src    = w_imm_src;
    assign bus.reg_src    = w_reg_src;
    assign bus.alu_ctl    = w_alu_ctl;
    assign bus.state      = r_state;

endmodule
